// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the ownership state encoding, CTI burst codes and the default watchdog limit.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating stall counter for the arbiter watchdog.
// fire is high while the count sits at TIMEOUT; the owner of this block clears it.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic fire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && (count_reg != LIMIT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign fire = (count_reg == LIMIT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone B3 arbiter with round-robin tie break and
// cycle-based ownership; a watchdog errors out accesses the slave never answers.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    localparam int SW = DW / 8;
    localparam int RW = AW + DW + SW + 1 + 3 + 2;

    arb_state_t    state_reg, state_next;
    logic          last_reg;
    logic [1:0]    grant_reg;
    logic [1:0]    cyc, stb;
    logic [RW-1:0] req [2];
    logic [RW-1:0] s_req;
    logic          owner_valid, owner_idx, owner_cyc, owner_req;
    logic          resp, wd_limit, force_idle, fire;
    logic [1:0]    ack, err, rty;

    assign cyc    = {m1_cyc_i, m0_cyc_i};
    assign stb    = {m1_stb_i, m0_stb_i};
    assign req[0] = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cti_i, m0_bte_i};
    assign req[1] = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cti_i, m1_bte_i};

    assign owner_valid = (state_reg != IDLE);
    assign owner_idx   = (state_reg == OWN1);
    assign owner_cyc   = owner_valid & cyc[owner_idx];
    assign owner_req   = owner_cyc & stb[owner_idx];
    assign resp        = s_ack_i | s_err_i | s_rty_i;

    // The watchdog decision is taken from registered state only, so a slave
    // that answers combinationally from stb cannot form a loop through fire.
    assign force_idle = wd_limit & owner_req;
    assign fire       = force_idle & ~resp;

    // Re-arbitrate whenever the current owner is not holding cyc.
    always_comb begin
        state_next = state_reg;
        if (!owner_cyc) begin
            if (cyc == 2'b11)  state_next = last_reg ? OWN0 : OWN1;
            else if (cyc[0])   state_next = OWN0;
            else if (cyc[1])   state_next = OWN1;
            else               state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            grant_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            grant_reg <= {state_next == OWN1, state_next == OWN0};
            if ((state_next != state_reg) && (state_next != IDLE))
                last_reg <= (state_next == OWN1);
        end
    end

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk_i),
        .rst_n    (nrst_i),
        .count_en (owner_req & ~resp),
        .clear    (~owner_req | resp | wd_limit | (state_next != state_reg)),
        .fire     (wd_limit)
    );

    assign s_req = owner_valid ? req[owner_idx] : '0;
    assign {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o} = s_req;
    assign s_cyc_o = owner_cyc & ~force_idle;
    assign s_stb_o = owner_req & ~force_idle;

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign ack[gi] = grant_reg[gi] & s_ack_i;
        assign err[gi] = grant_reg[gi] & (s_err_i | fire);
        assign rty[gi] = grant_reg[gi] & s_rty_i;
    end

    assign m0_ack_o  = ack[0];
    assign m0_err_o  = err[0];
    assign m0_rty_o  = rty[0];
    assign m1_ack_o  = ack[1];
    assign m1_err_o  = err[1];
    assign m1_rty_o  = rty[1];
    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign grant_o   = grant_reg;
    assign timeout_o = fire;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus a randomized
// run compared every cycle against an ownership/stall model of the arbiter rules.
module tb_wb_arbiter_2m;
    import wb_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;
    localparam int RW = AW + DW + SW + 6;

    logic          clk = 1'b0;
    logic          nrst;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic [SW-1:0] m_sel [2];
    logic          m_we  [2];
    logic [2:0]    m_cti [2];
    logic [1:0]    m_bte [2];
    logic          m_cyc [2];
    logic          m_stb [2];
    logic [DW-1:0] m_rdat [2];
    logic          m_ack [2];
    logic          m_err [2];
    logic          m_rty [2];
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic          s_we;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic          s_cyc, s_stb;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_err, s_rty;
    logic [1:0]    grant;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: owner is -1 (nobody), 0 or 1; stall counts consecutive
    // unanswered strobe cycles of the current owner.
    int owner, last, stall;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .nrst_i(nrst),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
        .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
        .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]), .m0_rty_o(m_rty[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
        .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
        .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]), .m1_rty_o(m_rty[1]),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cti_o(s_cti), .s_bte_o(s_bte), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant), .timeout_o(timeout)
    );

    function automatic bit mreq(int n);
        return m_cyc[n] && m_stb[n];
    endfunction

    task automatic model_reset();
        owner = -1;
        last  = 1;
        stall = 0;
    endtask

    task automatic model_step();
        int  nxt;
        bit  resp;
        bit  owner_holds;
        resp = s_ack || s_err || s_rty;
        owner_holds = (owner >= 0) ? m_cyc[owner] : 1'b0;
        nxt = owner;
        if (!owner_holds) begin
            if (m_cyc[0] && m_cyc[1]) nxt = 1 - last;
            else if (m_cyc[0])        nxt = 0;
            else if (m_cyc[1])        nxt = 1;
            else                      nxt = -1;
            if (nxt >= 0) last = nxt;
        end
        if (nxt != owner)                                          stall = 0;
        else if (owner >= 0 && mreq(owner) && !resp && stall < TO) stall++;
        else                                                       stall = 0;
        owner = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            m_adr[n] = '0; m_dat[n] = '0; m_sel[n] = '0; m_we[n] = 1'b0;
            m_cti[n] = CTI_CLASSIC; m_bte[n] = 2'b00; m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        s_rdat = $urandom;
    endtask

    task automatic start(int n, logic [AW-1:0] adr);
        m_cyc[n] = 1'b1; m_stb[n] = 1'b1; m_adr[n] = adr;
        m_sel[n] = '1; m_we[n] = 1'b0; m_dat[n] = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        start(0, 32'h40);
        s_ack = 1'b1;
        #3;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if ({s_cyc, s_stb, s_adr, s_wdat, s_sel, s_we, s_cti, s_bte} !== '0) begin
            errors++; $display("FAIL reset_slave_req: got cyc=%b stb=%b adr=%h want all 0", s_cyc, s_stb, s_adr); end
        checks++; if ({m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1], m_rty[1]} !== 6'b0) begin
            errors++; $display("FAIL reset_resp: got %b want 000000",
                               {m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1], m_rty[1]}); end
        checks++; if (m_rdat[1] !== s_rdat) begin errors++; $display("FAIL reset_rdat: got %h want %h", m_rdat[1], s_rdat); end
        @(posedge clk); #1;
        idle_inputs();
        nrst = 1'b1;
        model_reset();
        tick();
        $display("reset: outputs idle under reset");
    endtask

    task automatic test_tie();
        start(0, 32'h200); start(1, 32'h300);
        settle();
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", grant); end
        s_ack = 1'b1; settle();
        checks++; if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0) begin
            errors++; $display("FAIL tie_loser_quiet: got ack0=%b ack1=%b want 1/0", m_ack[0], m_ack[1]); end
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0; settle();
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL tie_release_cyc: got %b want 0", s_cyc); end
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_handoff: got %b want 10", grant); end
        checks++; if (s_adr !== 32'h300) begin errors++; $display("FAIL tie_handoff_adr: got %h want 300", s_adr); end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; settle();
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", grant); end
        start(0, 32'h204); start(1, 32'h304); settle();
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_second: got %b want 01", grant); end
        idle_inputs(); settle();
        tick();
        $display("tie: m0, m1, m0 granted in turn");
    endtask

    task automatic test_single();
        logic [DW-1:0] rd;
        start(0, 32'h100); settle();
        checks++; if (grant !== 2'b00 || s_stb !== 1'b0) begin
            errors++; $display("FAIL single_latency: got grant=%b stb=%b want 00/0", grant, s_stb); end
        tick();
        checks++; if (grant !== 2'b01 || s_stb !== 1'b1 || s_adr !== 32'h100) begin
            errors++; $display("FAIL single_grant: got grant=%b stb=%b adr=%h want 01/1/100", grant, s_stb, s_adr); end
        checks++; if (m_ack[0] !== 1'b0) begin errors++; $display("FAIL single_noack: got %b want 0", m_ack[0]); end
        tick();
        rd = $urandom; s_rdat = rd; s_ack = 1'b1; settle();
        checks++; if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0 || m_rdat[0] !== rd) begin
            errors++; $display("FAIL single_ack: got ack0=%b ack1=%b dat=%h want 1/0/%h", m_ack[0], m_ack[1], m_rdat[0], rd); end
        tick();
        idle_inputs(); settle();
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", grant); end
        $display("single: m0 read 0x100 data %h", rd);
    endtask

    task automatic test_burst();
        logic [2:0] ctis [4];
        ctis[0] = CTI_INCR; ctis[1] = CTI_INCR; ctis[2] = CTI_INCR; ctis[3] = CTI_EOB;
        start(1, 32'h1000); m_cti[1] = CTI_INCR; settle();
        tick();
        start(0, 32'h2000);
        for (int b = 0; b < 4; b++) begin
            m_adr[1] = 32'h1000 + 32'(4 * b); m_cti[1] = ctis[b]; s_ack = 1'b1; settle();
            checks++; if (grant !== 2'b10 || m_ack[1] !== 1'b1 || m_ack[0] !== 1'b0 || s_cti !== ctis[b]) begin
                errors++; $display("FAIL burst_beat%0d: got grant=%b ack1=%b ack0=%b cti=%b want 10/1/0/%b",
                                   b, grant, m_ack[1], m_ack[0], s_cti, ctis[b]); end
            tick();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0; settle();
        tick();
        checks++; if (grant !== 2'b01 || s_adr !== 32'h2000) begin
            errors++; $display("FAIL burst_switch: got grant=%b adr=%h want 01/2000", grant, s_adr); end
        idle_inputs(); settle();
        tick(); tick();
        $display("burst: m1 4-beat INCR then handoff to m0");
    endtask

    task automatic test_timeout();
        start(0, 32'h500); settle();
        tick();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < TO; i++) begin
                checks++; if (timeout !== 1'b0 || m_err[0] !== 1'b0 || s_stb !== 1'b1) begin
                    errors++; $display("FAIL timeout_early r%0d c%0d: got to=%b err=%b stb=%b want 0/0/1",
                                       round, i, timeout, m_err[0], s_stb); end
                tick();
            end
            checks++; if (timeout !== 1'b1 || m_err[0] !== 1'b1 || s_stb !== 1'b0 || s_cyc !== 1'b0) begin
                errors++; $display("FAIL timeout_fire r%0d: got to=%b err=%b stb=%b cyc=%b want 1/1/0/0",
                                   round, timeout, m_err[0], s_stb, s_cyc); end
            tick();
        end
        checks++; if (timeout !== 1'b0 || s_stb !== 1'b1) begin
            errors++; $display("FAIL timeout_pulse: got to=%b stb=%b want 0/1", timeout, s_stb); end
        idle_inputs(); settle();
        tick();
        $display("timeout: two watchdog errors %0d cycles apart", TO + 1);
    endtask

    task automatic test_race();
        start(0, 32'h600); settle();
        tick();
        for (int i = 0; i < TO; i++) tick();
        s_ack = 1'b1; settle();
        checks++; if (m_ack[0] !== 1'b1 || m_err[0] !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL race_ack_wins: got ack=%b err=%b to=%b want 1/0/0", m_ack[0], m_err[0], timeout); end
        tick();
        s_ack = 1'b0; settle();
        checks++; if (timeout !== 1'b0 || m_err[0] !== 1'b0 || s_stb !== 1'b1) begin
            errors++; $display("FAIL race_cleared: got to=%b err=%b stb=%b want 0/0/1", timeout, m_err[0], s_stb); end
        idle_inputs(); settle();
        tick();
        $display("race: ack beat watchdog");
    endtask

    task automatic test_reset_mid();
        start(1, 32'h700); m_cti[1] = CTI_INCR; settle();
        tick();
        s_ack = 1'b1; settle();
        tick();
        m_adr[1] = 32'h704; s_err = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== '0) begin
            errors++; $display("FAIL midreset_slave: got grant=%b cyc=%b stb=%b adr=%h want 00/0/0/0", grant, s_cyc, s_stb, s_adr); end
        checks++; if (m_ack[1] !== 1'b0 || m_err[1] !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL midreset_resp: got ack=%b err=%b to=%b want 0/0/0", m_ack[1], m_err[1], timeout); end
        @(posedge clk); #1;
        nrst = 1'b1; s_ack = 1'b0; s_err = 1'b0;
        model_reset();
        settle();
        tick();
        checks++; if (grant !== 2'b10 || s_adr !== 32'h704) begin
            errors++; $display("FAIL midreset_regrant: got grant=%b adr=%h want 10/704", grant, s_adr); end
        idle_inputs(); settle();
        tick();
        $display("reset_mid: m1 aborted and re-granted");
    endtask

    task automatic test_random();
        logic [RW-1:0] exp_req, got_req;
        logic [1:0]    exp_g;
        bit            frc, fire, resp, deaf, e_cyc, e_stb;
        int            r, o;
        for (int cyc_n = 0; cyc_n < 500; cyc_n++) begin
            deaf = (cyc_n >= 200 && cyc_n < 380);
            for (int n = 0; n < 2; n++) begin
                if (!m_cyc[n]) m_cyc[n] = ($urandom_range(3) == 0);
                else if ($urandom_range(deaf ? 31 : 7) == 0) m_cyc[n] = 1'b0;
                m_stb[n] = m_cyc[n] && (deaf || $urandom_range(4) != 0);
                m_adr[n] = $urandom; m_dat[n] = $urandom; m_sel[n] = SW'($urandom);
                m_we[n] = 1'($urandom); m_cti[n] = 3'($urandom); m_bte[n] = 2'($urandom);
            end
            r = $urandom_range(deaf ? 40 : 5);
            s_ack = (r == 0); s_err = (r == 1); s_rty = (r == 2);
            s_rdat = $urandom;
            settle();
            resp = s_ack || s_err || s_rty;
            exp_req = '0; e_cyc = 1'b0; e_stb = 1'b0; frc = 1'b0; exp_g = 2'b00;
            if (owner >= 0) begin
                o = owner;
                frc = mreq(o) && (stall == TO);
                exp_req = {m_adr[o], m_dat[o], m_sel[o], m_we[o], m_cti[o], m_bte[o]};
                e_cyc = m_cyc[o] && !frc;
                e_stb = mreq(o) && !frc;
                exp_g = (o == 0) ? 2'b01 : 2'b10;
            end
            fire = frc && !resp;
            got_req = {s_adr, s_wdat, s_sel, s_we, s_cti, s_bte};
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rnd_grant @%0d: got %b want %b", cyc_n, grant, exp_g); end
            checks++; if (got_req !== exp_req || s_cyc !== e_cyc || s_stb !== e_stb) begin
                errors++; $display("FAIL rnd_slave_req @%0d: got %h cyc=%b stb=%b want %h cyc=%b stb=%b",
                                   cyc_n, got_req, s_cyc, s_stb, exp_req, e_cyc, e_stb); end
            checks++; if (timeout !== fire) begin errors++; $display("FAIL rnd_timeout @%0d: got %b want %b", cyc_n, timeout, fire); end
            for (int n = 0; n < 2; n++) begin
                checks++;
                if (m_ack[n] !== (exp_g[n] & s_ack) || m_rty[n] !== (exp_g[n] & s_rty) ||
                    m_err[n] !== (exp_g[n] & (s_err | fire)) || m_rdat[n] !== s_rdat) begin
                    errors++; $display("FAIL rnd_resp%0d @%0d: got ack=%b err=%b rty=%b dat=%h want %b/%b/%b/%h",
                                       n, cyc_n, m_ack[n], m_err[n], m_rty[n], m_rdat[n],
                                       exp_g[n] & s_ack, exp_g[n] & (s_err | fire), exp_g[n] & s_rty, s_rdat); end
            end
            if (fire) $display("random @%0d: watchdog fired for m%0d", cyc_n, owner);
            tick();
        end
        idle_inputs(); settle();
        tick();
        $display("random: 500 cycles compared against model");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tie();
        test_single();
        test_burst();
        test_timeout();
        test_race();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master, one-slave Wishbone B3 arbiter that lets the CPU instruction master (m0) and data master (m1) share a single slave port, typically the system SRAM. Ownership is cycle-based: a granted master keeps the slave for as long as it holds `cyc`, which covers CTI bursts. Ties are broken round-robin. A watchdog terminates any access the slave leaves unanswered with an error. It sits between the CPU wrapper and the bus matrix slave port.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` width is `DW/8`.
- `TIMEOUT`, 255: cycles of `stb` without a slave response before a forced `err`; range 2..65535.
- `clk_i` in 1: system clock; every flop is on the rising edge.
- `nrst_i` in 1: asynchronous, active-low reset.
- `mN_adr_i` in AW, `mN_dat_i` in DW, `mN_sel_i` in DW/8, `mN_we_i` in 1, `mN_cti_i` in 3, `mN_bte_i` in 2, `mN_cyc_i` in 1, `mN_stb_i` in 1: master N request (N = 0, 1).
- `mN_dat_o` out DW, `mN_ack_o` out 1, `mN_err_o` out 1, `mN_rty_o` out 1: master N response.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out DW/8, `s_we_o` out 1, `s_cti_o` out 3, `s_bte_o` out 2, `s_cyc_o` out 1, `s_stb_o` out 1: slave request.
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1, `s_rty_i` in 1: slave response.
- `grant_o` out 2: one-hot current owner; 00 when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states are IDLE, OWN0 and OWN1, all registered. Reset state is IDLE.
- Priority pointer `last`: reset value 1, so m0 wins the first tie. It updates to the index of each new owner.
- Arbitration decision, taken in IDLE or on the cycle the owner's `cyc` is low:
  - only m0 `cyc` high: go to OWN0;
  - only m1 `cyc` high: go to OWN1;
  - both high: grant the master that is not `last`;
  - neither high: go to IDLE.
- Handoff is direct (OWN0 to OWN1 or back); there is no idle bubble.
- While in OWNn:
  - all slave request outputs equal master n's inputs, with `s_cyc_o`/`s_stb_o` gated by `mn_cyc_i`;
  - master n's `ack`/`rty` follow the slave's; `err` = `s_err_i` OR watchdog fire;
  - the other master's `ack`/`err`/`rty` are held at 0.
- In IDLE all slave request outputs are 0.
- `mN_dat_o` = `s_dat_i` for both masters at all times; it is only valid when qualified by `ack`.
- Watchdog:
  - the counter increments every cycle the owner has `stb` high and the slave gives no `ack`/`err`/`rty`;
  - it clears on any slave response, on `stb` low, and on an ownership change;
  - when the count reaches `TIMEOUT-1`, the next cycle asserts owner `err` and `timeout_o` for one cycle, forces `s_cyc_o`/`s_stb_o` low for that cycle, and clears the counter.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values: `grant_o`=00, `timeout_o`=0, all `s_*_o`=0, all `mN_ack/err/rty_o`=0. `mN_dat_o` follows `s_dat_i` combinationally.
- Arbitration latency: if `cyc`/`stb` rise in cycle t with the arbiter IDLE, the slave sees the request in cycle t+1.
- Response path: combinational slave-to-master with zero added latency. Back-to-back pipelined acks within one owner are passed through unchanged.
- Release: if the owner drops `cyc` in cycle t and the other master is requesting, the other master is granted from t+1.
- Simultaneous slave `ack` and watchdog fire: `ack` wins, and the counter clears.
- Simultaneous `cyc` on both masters from IDLE: grant goes to `!last`; the losing master waits with no response.
- Reset asserted mid-burst: all outputs return to their reset values immediately, independent of the clock. After reset is released, the FSM is in IDLE and `last`=1.
- `rty` from the slave does not release ownership; the owner decides whether to retry.

## Structure
- Package `wb_arb_pkg`: state enum (IDLE/OWN0/OWN1), CTI constants (CLASSIC=000, INCR=010, EOB=111), and the default `TIMEOUT`.
- Sub-module `wb_arb_watchdog`: parameterised counter with `count_en`, `clear`, and a `fire` output. The arbiter top holds the FSM, the pointer, and the muxes.

## Test plan
- Single master: m0 reads address 0x100 and the slave acks on its 2nd cycle. Required: `grant_o`=01 from t+1, `m0_ack_o` equals `s_ack_i`, and `m1_ack_o` stays 0.
- Tie after reset: m0 and m1 raise `cyc` in the same cycle. Required: m0 is granted first. When m0 drops `cyc`, m1 owns from the next cycle. On a second tie, m0 is granted again (the pointer alternates).
- Burst hold: m1 runs a 4-beat INCR burst (cti 010,010,010,111) while m0 requests throughout. Required: `grant_o` stays 10 for all 4 acks, then switches to 01.
- Timeout: with `TIMEOUT`=8, m0 holds `stb` and the slave never responds. Required: `m0_err_o` and `timeout_o` pulse exactly 8 cycles after `stb` reaches the slave, `s_stb_o` is low that cycle, and the access resumes counting from 0 afterwards.
- Ack vs. timeout race: the slave acks on exactly the cycle the watchdog would fire. Required: `m0_ack_o`=1, `m0_err_o`=0, `timeout_o`=0.
- Reset mid-transfer: assert `nrst_i` low during m1's beat 2. Required: all `s_*_o`, `grant_o` and responses are 0 in the same cycle. After release, m1's re-request is granted within one cycle.
